// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register file write-port arbiter with MDU result FIFO and pending-write scoreboard
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  pwb_we,
    input  logic [ADDR_WIDTH-1:0] pwb_wa,
    input  logic [DATA_WIDTH-1:0] pwb_wd,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [ADDR_WIDTH-1:0] mdu_wa,
    input  logic [DATA_WIDTH-1:0] mdu_wd,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_wa,
    input  logic [ADDR_WIDTH-1:0] chk_ra0,
    input  logic [ADDR_WIDTH-1:0] chk_ra1,
    input  logic [ADDR_WIDTH-1:0] chk_wa,
    output logic                  busy0,
    output logic                  busy1,
    output logic                  busy_wa,
    output logic                  stall_req,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_wa,
    output logic [DATA_WIDTH-1:0] rf_wd
);

    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int SW   = $clog2(STARVE_LIMIT + 1);
    localparam int NREG = 1 << ADDR_WIDTH;

    // MDU result buffer
    logic [ADDR_WIDTH-1:0] fifo_wa [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wd [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;

    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] head_wa;
    logic [DATA_WIDTH-1:0] head_wd;

    // Pending MDU writes, one bit per architectural register
    logic [NREG-1:0]       pend;
    logic [NREG-1:0]       pend_next;

    logic [SW-1:0]         starve_cnt;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign head_wa = fifo_wa[rd_ptr];
    assign head_wd = fifo_wd[rd_ptr];

    // Ready depends only on registered occupancy, so a full FIFO never takes a push
    assign mdu_ready = rstn && !full;
    assign push      = mdu_valid && mdu_ready;

    // The pipeline always wins; the FIFO drains only in cycles the pipeline leaves free
    assign pop       = rstn && !pwb_we && !empty;

    assign stall_req = rstn && (starve_cnt == SW'(STARVE_LIMIT));

    assign busy0   = rstn && pend[chk_ra0];
    assign busy1   = rstn && pend[chk_ra1];
    assign busy_wa = rstn && pend[chk_wa];

    // Write-port mux; register 0 is hardwired so writes to it are suppressed
    always_comb begin
        rf_we = 1'b0;
        rf_wa = pwb_wa;
        rf_wd = pwb_wd;
        if (rstn) begin
            if (pwb_we) begin
                rf_we = (pwb_wa != '0);
            end else if (!empty) begin
                rf_wa = head_wa;
                rf_wd = head_wd;
                rf_we = (head_wa != '0);
            end
        end
    end

    // FIFO payload storage; written only on an accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wa[wr_ptr] <= mdu_wa;
            fifo_wd[wr_ptr] <= mdu_wd;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Next scoreboard: clear on pop first so a same-address issue overrides it
    always_comb begin
        pend_next = pend;
        if (pop) begin
            pend_next[head_wa] = 1'b0;
        end
        if (iss_valid && (iss_wa != '0)) begin
            pend_next[iss_wa] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    // Starvation counter: counts cycles the FIFO waits behind the pipeline
    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (empty || pop) begin
            starve_cnt <= '0;
        end else if (pwb_we && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard testbench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wr_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          pwb_we;
    logic [AW-1:0] pwb_wa;
    logic [DW-1:0] pwb_wd;
    logic          mdu_valid;
    logic          mdu_ready;
    logic [AW-1:0] mdu_wa;
    logic [DW-1:0] mdu_wd;
    logic          iss_valid;
    logic [AW-1:0] iss_wa;
    logic [AW-1:0] chk_ra0;
    logic [AW-1:0] chk_ra1;
    logic [AW-1:0] chk_wa;
    logic          busy0;
    logic          busy1;
    logic          busy_wa;
    logic          stall_req;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    // staged stimulus, applied at the next falling edge
    logic          s_rstn, s_pwb_we, s_mdu_valid, s_iss_valid;
    logic [AW-1:0] s_pwb_wa, s_mdu_wa, s_iss_wa, s_c0, s_c1, s_cw;
    logic [DW-1:0] s_pwb_wd, s_mdu_wd;

    // reference model
    wr_t m_fifo[$];
    bit  m_pend[32];
    int  m_starve;
    int  iss_q[$];
    wr_t exp_q[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .pwb_we(pwb_we), .pwb_wa(pwb_wa), .pwb_wd(pwb_wd),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_wa(mdu_wa), .mdu_wd(mdu_wd),
        .iss_valid(iss_valid), .iss_wa(iss_wa),
        .chk_ra0(chk_ra0), .chk_ra1(chk_ra1), .chk_wa(chk_wa),
        .busy0(busy0), .busy1(busy1), .busy_wa(busy_wa),
        .stall_req(stall_req),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        s_rstn = 1'b1; s_pwb_we = 1'b0; s_mdu_valid = 1'b0; s_iss_valid = 1'b0;
        s_pwb_wa = '0; s_pwb_wd = '0; s_mdu_wa = '0; s_mdu_wd = '0; s_iss_wa = '0;
        s_c0 = '0; s_c1 = '0; s_cw = '0;
    endtask

    // one clock: apply staged inputs, check level outputs, push expected write, advance model
    task automatic tick();
        bit  exp_ready, was_empty, popped;
        wr_t head;
        @(negedge clk);
        rstn = s_rstn; pwb_we = s_pwb_we; pwb_wa = s_pwb_wa; pwb_wd = s_pwb_wd;
        mdu_valid = s_mdu_valid; mdu_wa = s_mdu_wa; mdu_wd = s_mdu_wd;
        iss_valid = s_iss_valid; iss_wa = s_iss_wa;
        chk_ra0 = s_c0; chk_ra1 = s_c1; chk_wa = s_cw;
        #1;
        if (!s_rstn) begin
            check("rst_mdu_ready", {31'd0, mdu_ready}, 0);
            check("rst_stall_req", {31'd0, stall_req}, 0);
            check("rst_rf_we", {31'd0, rf_we}, 0);
            check("rst_busy", {29'd0, busy0, busy1, busy_wa}, 0);
            m_fifo.delete();
            iss_q.delete();
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_starve = 0;
            return;
        end
        exp_ready = (m_fifo.size() < DEPTH);
        check("mdu_ready", {31'd0, mdu_ready}, {31'd0, exp_ready});
        check("stall_req", {31'd0, stall_req}, (m_starve == LIMIT) ? 1 : 0);
        check("busy0", {31'd0, busy0}, {31'd0, m_pend[s_c0]});
        check("busy1", {31'd0, busy1}, {31'd0, m_pend[s_c1]});
        check("busy_wa", {31'd0, busy_wa}, {31'd0, m_pend[s_cw]});

        was_empty = (m_fifo.size() == 0);
        popped = 1'b0;
        if (s_pwb_we) begin
            if (s_pwb_wa != 0) exp_q.push_back('{wa: s_pwb_wa, wd: s_pwb_wd});
        end else if (!was_empty) begin
            head = m_fifo.pop_front();
            popped = 1'b1;
            if (head.wa != 0) exp_q.push_back(head);
            m_pend[head.wa] = 1'b0;
        end
        if (s_iss_valid && s_iss_wa != 0) begin
            m_pend[s_iss_wa] = 1'b1;
            iss_q.push_back(int'(s_iss_wa));
        end
        if (s_mdu_valid && exp_ready) begin
            m_fifo.push_back('{wa: s_mdu_wa, wd: s_mdu_wd});
            if (iss_q.size() > 0 && iss_q[0] == int'(s_mdu_wa)) void'(iss_q.pop_front());
        end
        if (popped || was_empty) m_starve = 0;
        else if (s_pwb_we && m_starve < LIMIT) m_starve++;
    endtask

    // monitor: every presented write must match the next expected write
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write actual wa=%0d wd=%h required=no write", rf_wa, rf_wd);
                end else begin
                    e = exp_q.pop_front();
                    check("rf_wa", {27'd0, rf_wa}, {27'd0, e.wa});
                    check("rf_wd", rf_wd, e.wd);
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++; fails++;
                $display("FAIL missing_write actual=no write required wa=%0d wd=%h", e.wa, e.wd);
            end
        end
    end

    initial begin
        m_starve = 0;
        idle();
        rstn = 1'b0; pwb_we = 1'b0; pwb_wa = '0; pwb_wd = '0; mdu_valid = 1'b0;
        mdu_wa = '0; mdu_wd = '0; iss_valid = 1'b0; iss_wa = '0;
        chk_ra0 = '0; chk_ra1 = '0; chk_wa = '0;

        // reset with an MDU result offered
        s_rstn = 1'b0; s_mdu_valid = 1'b1; s_mdu_wa = 5'd4; s_mdu_wd = 32'hDEAD;
        tick(); tick();
        idle(); tick();
        check("post_rst_ready", {31'd0, mdu_ready}, 1);

        // idle MDU path on r5
        idle(); s_iss_valid = 1'b1; s_iss_wa = 5'd5; s_c0 = 5'd5; tick();
        idle(); s_mdu_valid = 1'b1; s_mdu_wa = 5'd5; s_mdu_wd = 32'h1234; s_c0 = 5'd5; tick();
        check("mdu_busy0_pending", {31'd0, busy0}, 1);
        idle(); s_c0 = 5'd5; tick();
        check("mdu_write_wa", {27'd0, rf_wa}, 5);
        check("mdu_write_wd", rf_wd, 32'h1234);
        idle(); s_c0 = 5'd5; tick();
        check("mdu_busy0_cleared", {31'd0, busy0}, 0);

        // pipeline priority over a buffered r7 result
        idle(); s_iss_valid = 1'b1; s_iss_wa = 5'd7; s_mdu_valid = 1'b1; s_mdu_wa = 5'd7;
        s_mdu_wd = 32'h77; s_pwb_we = 1'b1; s_pwb_wa = 5'd1; s_pwb_wd = 32'h11; tick();
        idle(); s_pwb_we = 1'b1; s_pwb_wa = 5'd3; s_pwb_wd = 32'hAA; tick();
        check("prio_pwb_wa", {27'd0, rf_wa}, 3);
        idle(); tick();
        check("prio_fifo_wa", {27'd0, rf_wa}, 7);

        // fill the FIFO behind the pipeline
        idle(); s_pwb_we = 1'b1; s_pwb_wa = 5'd2; s_mdu_valid = 1'b1; s_mdu_wa = 5'd10; s_mdu_wd = 32'hA0; tick();
        idle(); s_pwb_we = 1'b1; s_pwb_wa = 5'd2; s_mdu_valid = 1'b1; s_mdu_wa = 5'd11; s_mdu_wd = 32'hB0; tick();
        idle(); s_pwb_we = 1'b1; s_pwb_wa = 5'd2; s_mdu_valid = 1'b1; s_mdu_wa = 5'd12; s_mdu_wd = 32'hC0; tick();
        check("full_ready_low", {31'd0, mdu_ready}, 0);
        idle(); tick();
        check("full_ready_during_pop", {31'd0, mdu_ready}, 0);
        idle(); tick();
        check("full_ready_after_pop", {31'd0, mdu_ready}, 1);

        // starvation bubble
        idle(); s_pwb_we = 1'b1; s_pwb_wa = 5'd6; s_mdu_valid = 1'b1; s_mdu_wa = 5'd13; s_mdu_wd = 32'hD0; tick();
        for (int i = 0; i < LIMIT; i++) begin
            idle(); s_pwb_we = 1'b1; s_pwb_wa = 5'd6; s_pwb_wd = 32'(i); tick();
        end
        idle(); tick();
        check("starve_stall_high", {31'd0, stall_req}, 1);
        check("starve_head_wa", {27'd0, rf_wa}, 13);
        idle(); tick();
        check("starve_stall_low", {31'd0, stall_req}, 0);

        // register zero and same-cycle set/clear on r9
        idle(); s_mdu_valid = 1'b1; s_mdu_wa = 5'd0; s_mdu_wd = 32'hFFFF; tick();
        idle(); tick();
        check("zero_rf_we", {31'd0, rf_we}, 0);
        idle(); s_iss_valid = 1'b1; s_iss_wa = 5'd0; tick();
        idle(); s_cw = 5'd0; tick();
        check("zero_busy", {31'd0, busy_wa}, 0);
        idle(); s_iss_valid = 1'b1; s_iss_wa = 5'd9; s_pwb_we = 1'b1; s_pwb_wa = 5'd8;
        s_mdu_valid = 1'b1; s_mdu_wa = 5'd9; s_mdu_wd = 32'h99; tick();
        idle(); s_iss_valid = 1'b1; s_iss_wa = 5'd9; s_c1 = 5'd9; tick();
        idle(); s_c1 = 5'd9; tick();
        check("set_wins_busy1", {31'd0, busy1}, 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            s_rstn = ($urandom_range(0, 249) != 0);
            s_pwb_we = (m_starve == LIMIT) ? 1'b0 : ($urandom_range(0, 99) < 55);
            s_pwb_wa = AW'($urandom); s_pwb_wd = $urandom;
            s_iss_wa = AW'($urandom);
            s_iss_valid = ($urandom_range(0, 2) == 0) && !m_pend[s_iss_wa];
            if (iss_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                s_mdu_valid = 1'b1; s_mdu_wa = AW'(iss_q[0]); s_mdu_wd = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                s_mdu_valid = 1'b1; s_mdu_wa = '0; s_mdu_wd = $urandom;
            end
            s_c0 = AW'($urandom); s_c1 = AW'($urandom); s_cw = AW'($urandom);
            tick();
        end

        // drain and confirm nothing expected was left unseen
        for (int n = 0; n < DEPTH + 2; n++) begin
            idle(); tick();
        end
        check("drain_exp_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
